// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Purpose  : Instruction-memory responder for the fetch path. Translates
//            byte fetch addresses to word indices relative to BASE_ADDR and
//            returns the instruction word after LATENCY clock edges. Flags
//            misaligned or out-of-range fetches, drops in-flight responses on
//            a branch flush, and supports single-word program loading.
// Ports    : clock, reset (async, active-low)
//            req_valid/req_address/req_ready  - fetch request channel
//            flush                            - kill in-flight responses
//            wr_en/wr_index/wr_data           - program-load write port
//            resp_valid/resp_instr/resp_address/resp_error - response
//            fetch_count (16b), error_count (8b) - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h18C0,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = 32'h0,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [31:0]      req_address,
    output logic             req_ready,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [31:0]      wr_data,
    output logic             resp_valid,
    output logic [31:0]      resp_instr,
    output logic [31:0]      resp_address,
    output logic             resp_error,
    output logic [15:0]      fetch_count,
    output logic [7:0]       error_count
);

    // Window size in bytes; off >= span is the same test as off[31:2] >= DEPTH.
    localparam logic [31:0] c_span_bytes = 32'(DEPTH_WORDS) << 2;

    logic [31:0]      r_mem [DEPTH_WORDS];

    // Stage LATENCY-1 is the response register itself.
    logic             r_vld   [LATENCY];
    logic             r_err   [LATENCY];
    logic [31:0]      r_addr  [LATENCY];
    logic [31:0]      r_instr [LATENCY];

    logic [15:0]      r_fetch_count;
    logic [7:0]       r_error_count;

    logic             w_accept;
    logic [31:0]      w_off;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic             w_deliver;
    logic             w_deliver_err;
    logic             w_unused;

    // Writes win over fetches: nothing is accepted in a load cycle.
    assign req_ready = ~wr_en;
    assign w_accept  = req_valid & ~wr_en;

    assign w_off  = req_address - BASE_ADDR;
    assign w_err  = (req_address[1:0] != 2'b00) | (req_address < BASE_ADDR) |
                    (w_off >= c_span_bytes);
    assign w_idx  = w_off[2 +: IDX_W];
    assign w_word = w_err ? NOP_WORD : r_mem[w_idx];

    assign w_unused = ^{w_off[1:0], w_off[31:2+IDX_W]};

    // Delivery happens on the edge that loads a valid entry into the
    // response stage; flush suppresses everything except a same-edge accept.
    generate
        if (LATENCY == 1) begin : g_lat_one
            assign w_deliver     = w_accept;
            assign w_deliver_err = w_err;
        end else begin : g_lat_multi
            assign w_deliver     = r_vld[LATENCY-2] & ~flush;
            assign w_deliver_err = r_err[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_index] <= wr_data;
        end
    end

    // Data fields only load with a valid entry, so the response stage holds
    // the last delivered values while resp_valid is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]   <= 1'b0;
                r_err[i]   <= 1'b0;
                r_addr[i]  <= 32'h0;
                r_instr[i] <= NOP_WORD;
            end
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_err[0]   <= w_err;
                r_addr[0]  <= req_address;
                r_instr[0] <= w_word;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1] & ~flush;
                if (r_vld[i-1] & ~flush) begin
                    r_err[i]   <= r_err[i-1];
                    r_addr[i]  <= r_addr[i-1];
                    r_instr[i] <= r_instr[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= 16'h0;
            r_error_count <= 8'h0;
        end else if (w_deliver) begin
            if (w_deliver_err) begin
                if (r_error_count != 8'hFF) begin
                    r_error_count <= r_error_count + 8'd1;
                end
            end else begin
                if (r_fetch_count != 16'hFFFF) begin
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
            end
        end
    end

    assign resp_valid   = r_vld[LATENCY-1];
    assign resp_instr   = r_instr[LATENCY-1];
    assign resp_address = r_addr[LATENCY-1];
    assign resp_error   = r_err[LATENCY-1];
    assign fetch_count  = r_fetch_count;
    assign error_count  = r_error_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Purpose  : Self-checking bench for instr_mem_responder. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios add literal expectations on top of the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

    localparam logic [31:0] BASE  = 32'h18C0;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_address = 32'h0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_index = 8'h0;
    logic [31:0] wr_data = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic [31:0] resp_address;
    logic        resp_error;
    logic [15:0] fetch_count;
    logic [7:0]  error_count;

    instr_mem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .NOP_WORD   (32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_address (req_address),
        .req_ready   (req_ready),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_data     (wr_data),
        .resp_valid  (resp_valid),
        .resp_instr  (resp_instr),
        .resp_address(resp_address),
        .resp_error  (resp_error),
        .fetch_count (fetch_count),
        .error_count (error_count)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          due;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          at;
    } seen_t;

    ent_t        q[$];
    seen_t       seen[$];
    logic [31:0] m_mem [DEPTH];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_addr  = 32'h0;
    logic        m_err   = 1'b0;
    int          m_fetch = 0;
    int          m_errc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_addr  = 32'h0;
        m_err   = 1'b0;
        m_fetch = 0;
        m_errc  = 0;
    endtask

    // One clock edge of the fetch contract: flush kills older entries, an
    // accepted request becomes deliverable LAT-1 edges later.
    task automatic model_step();
        ent_t        e;
        logic [31:0] off;
        if (flush) q.delete();
        if (req_valid && !wr_en) begin
            off     = req_address - BASE;
            e.addr  = req_address;
            e.err   = (req_address % 4 != 0) || (req_address < BASE) || (off / 4 >= DEPTH);
            e.instr = e.err ? 32'h0 : m_mem[(off / 4) % DEPTH];
            e.due   = cyc + LAT - 1;
            q.push_back(e);
        end
        if (wr_en) m_mem[wr_index] = wr_data;
        m_valid = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e       = q.pop_front();
            m_valid = 1'b1;
            m_instr = e.instr;
            m_addr  = e.addr;
            m_err   = e.err;
            if (e.err) m_errc  = (m_errc  == 255)   ? 255   : m_errc + 1;
            else       m_fetch = (m_fetch == 65535) ? 65535 : m_fetch + 1;
        end
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clock) begin
        if (reset) model_step();
        else       model_reset();
        #1;
        check("resp_valid",   32'(resp_valid),   32'(m_valid));
        check("resp_instr",   resp_instr,        m_instr);
        check("resp_address", resp_address,      m_addr);
        check("resp_error",   32'(resp_error),   32'(m_err));
        check("fetch_count",  32'(fetch_count),  32'(m_fetch));
        check("error_count",  32'(error_count),  32'(m_errc));
        check("req_ready",    32'(req_ready),    32'(!wr_en));
        if (resp_valid) seen.push_back('{resp_address, resp_instr, resp_error, cyc});
        cyc++;
    end

    task automatic drive(input logic rv, input logic [31:0] a, input logic fl,
                         input logic we, input logic [7:0] wi, input logic [31:0] wd);
        @(negedge clock);
        req_valid   = rv;
        req_address = a;
        flush       = fl;
        wr_en       = we;
        wr_index    = wi;
        wr_data     = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        drive(1'b1, a, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Program load: words 0..4 get recognisable values, rest random.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 8'(i), (i < 5) ? (32'hA000_0000 + 32'(i)) : $urandom);
        end
        idle(2);

        // Back-to-back aligned fetches.
        seen.delete();
        fetch(32'h18C0); fetch(32'h18C4); fetch(32'h18C8);
        idle(4);
        check("t1_count", 32'(seen.size()), 32'd3);
        check("t1_i0", seen[0].instr, 32'hA000_0000);
        check("t1_i1", seen[1].instr, 32'hA000_0001);
        check("t1_i2", seen[2].instr, 32'hA000_0002);
        check("t1_consecutive", 32'(seen[2].at - seen[0].at), 32'd2);

        // Misaligned, below base, one past the end.
        seen.delete();
        fetch(32'h18C2); fetch(32'h18BC); fetch(BASE + 32'(4 * DEPTH));
        idle(4);
        check("t2_count", 32'(seen.size()), 32'd3);
        check("t2_err0", 32'(seen[0].err), 32'd1);
        check("t2_err2", 32'(seen[2].err), 32'd1);
        check("t2_nop1", seen[1].instr, 32'h0);
        check("t2_errc", 32'(error_count), 32'd3);
        check("t2_fetchc", 32'(fetch_count), 32'd3);

        // Flush with a redirected fetch on the edge after the second accept.
        // With a two-edge latency the first fetch is already out by then;
        // only the second is still in flight and gets killed.
        seen.delete();
        fetch(32'h18C0); fetch(32'h18C4);
        drive(1'b1, 32'h18D0, 1'b1, 1'b0, 8'h0, 32'h0);
        idle(4);
        check("t3_count", 32'(seen.size()), 32'd2);
        check("t3_first", seen[0].instr, 32'hA000_0000);
        check("t3_addr", seen[1].addr, 32'h18D0);
        check("t3_instr", seen[1].instr, 32'hA000_0004);

        // Write blocks requests; in-flight fetch keeps the old word.
        seen.delete();
        drive(1'b1, 32'h18C4, 1'b0, 1'b1, 8'd7, 32'h7777_7777);
        fetch(32'h18C4);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 8'd1, 32'hDEAD_BEEF);
        idle(3);
        fetch(32'h18C4);
        idle(3);
        check("t4_count", 32'(seen.size()), 32'd2);
        check("t4_old", seen[0].instr, 32'hA000_0001);
        check("t4_new", seen[1].instr, 32'hDEAD_BEEF);

        // Asynchronous reset mid-stream.
        fetch(32'h18C0); fetch(32'h18C8);
        @(posedge clock);
        #3;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        seen.delete();
        check("t5_valid", 32'(resp_valid), 32'd0);
        check("t5_instr", resp_instr, 32'h0);
        check("t5_addr", resp_address, 32'h0);
        check("t5_fetchc", 32'(fetch_count), 32'd0);
        check("t5_errc", 32'(error_count), 32'd0);
        idle(2);
        @(negedge clock);
        reset = 1'b1;
        idle(5);
        check("t5_no_resp", 32'(seen.size()), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 64));
            else               a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
            drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 9) == 0), 8'($urandom), $urandom);
        end
        idle(4);

        // Counter saturation.
        @(negedge clock);
        dut.r_fetch_count = 16'hFFFE;
        m_fetch = 32'hFFFE;
        fetch(32'h18C0); fetch(32'h18C4); fetch(32'h18C8);
        idle(4);
        check("t6_fetch_sat", 32'(fetch_count), 32'hFFFF);
        for (int n = 0; n < 260; n++) fetch(32'h18C1);
        idle(4);
        check("t6_err_sat", 32'(error_count), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
